// File: rtl/memory_router.sv
// memory_router: registered router from one core memory port to REGION_COUNT target ports.
// Optional target watchdog: define MEMORY_ROUTER_TIMEOUT_EN.
module memory_router #(
  parameter int unsigned REGION_ADDRESS_WIDTH = 28,
  parameter int unsigned REGION_COUNT         = 2,
  parameter int unsigned TIMEOUT_CYCLES       = 255
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [31:0]                                  coreAddress,
  input  logic [3:0]                                   coreByteSelect,
  input  logic                                         coreWriteEnable,
  input  logic                                         coreReadEnable,
  input  logic [31:0]                                  coreDataWrite,
  output logic [31:0]                                  coreDataRead,
  output logic                                         coreBusy,
  output logic                                         coreError,
  output logic [31:0]                                  errorAddress,
  output logic [REGION_COUNT*REGION_ADDRESS_WIDTH-1:0] targetAddress,
  output logic [REGION_COUNT*4-1:0]                    targetByteSelect,
  output logic [REGION_COUNT-1:0]                      targetWriteEnable,
  output logic [REGION_COUNT-1:0]                      targetReadEnable,
  output logic [REGION_COUNT*32-1:0]                   targetDataWrite,
  input  logic [REGION_COUNT*32-1:0]                   targetDataRead,
  input  logic [REGION_COUNT-1:0]                      targetBusy
);

  localparam int unsigned AW    = REGION_ADDRESS_WIDTH;
  localparam int unsigned IDX_W = 32 - AW;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESPOND} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    bsel;
    logic          we;
    logic          re;
    logic [31:0]   wdata;
  } req_t;

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic             core_req;
  logic [IDX_W-1:0] core_idx;
  logic             core_mapped;
  logic             sel_busy;
  logic [31:0]      sel_rdata;
  logic             timeout;
  logic [31:0]      timeout_addr;

  assign core_req    = coreReadEnable | coreWriteEnable;
  assign core_idx    = coreAddress[31:AW];
  assign core_mapped = 33'(core_idx) < 33'(REGION_COUNT);

  // Busy and read data of the latched target.
  always_comb begin
    sel_busy  = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < REGION_COUNT; i++) begin
      if (33'(idx_q) == 33'(i)) begin
        sel_busy  = targetBusy[i];
        sel_rdata = targetDataRead[i*32 +: 32];
      end
    end
  end

`ifdef MEMORY_ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_full_q, addr_full_d;

  // Counter is held at zero in IDLE so every ACTIVE phase starts from zero.
  always_comb begin
    cnt_d       = cnt_q;
    addr_full_d = addr_full_q;
    timeout     = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (core_req) addr_full_d = coreAddress;
    end else if (state_q == ACTIVE && sel_busy) begin
      cnt_d   = cnt_q + CNT_W'(1);
      timeout = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      addr_full_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      addr_full_q <= addr_full_d;
    end
  end

  assign timeout_addr = addr_full_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
  assign timeout_addr       = '0;
`endif

  // Next-state logic and transaction capture.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    idx_d      = idx_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (core_req) begin
          req_d.addr  = coreAddress[AW-1:0];
          req_d.bsel  = coreByteSelect;
          req_d.we    = coreWriteEnable;
          req_d.re    = coreReadEnable;
          req_d.wdata = coreDataWrite;
          idx_d       = core_idx;
          if (core_mapped) begin
            state_d = ACTIVE;
          end else begin
            err_d      = 1'b1;
            rdata_d    = '0;
            err_addr_d = coreAddress;
            state_d    = RESPOND;
          end
        end
      end
      ACTIVE: begin
        if (!sel_busy) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = RESPOND;
        end else if (timeout) begin
          rdata_d    = '0;
          err_d      = 1'b1;
          err_addr_d = timeout_addr;
          state_d    = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      idx_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      idx_q      <= idx_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Only the latched target's slice is driven, and only while ACTIVE.
  always_comb begin
    targetAddress     = '0;
    targetByteSelect  = '0;
    targetWriteEnable = '0;
    targetReadEnable  = '0;
    targetDataWrite   = '0;
    if (state_q == ACTIVE) begin
      for (int unsigned i = 0; i < REGION_COUNT; i++) begin
        if (33'(idx_q) == 33'(i)) begin
          targetAddress[i*AW +: AW]   = req_q.addr;
          targetByteSelect[i*4 +: 4]  = req_q.bsel;
          targetWriteEnable[i]        = req_q.we;
          targetReadEnable[i]         = req_q.re;
          targetDataWrite[i*32 +: 32] = req_q.wdata;
        end
      end
    end
  end

  always_comb begin
    coreBusy = 1'b0;
    case (state_q)
      IDLE:    coreBusy = core_req;
      ACTIVE:  coreBusy = 1'b1;
      default: coreBusy = 1'b0;
    endcase
  end

  assign coreDataRead = (state_q == RESPOND) ? rdata_q : '0;
  assign coreError    = (state_q == RESPOND) & err_q;
  assign errorAddress = err_addr_q;

endmodule
